// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch / load-store arbiter in front of one single-port RAM with one-cycle read latency.
// Build option MEM_ARB_RR_EN: round-robin contention; undefined: load/store priority with fetch starvation guard.
module mem_arbiter #(
  parameter int WIDTH    = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_if_req,
  input  logic [WIDTH-1:0] i_if_addr,
  output logic             o_if_gnt,
  output logic             o_if_rvalid,
  output logic [31:0]      o_if_rdata,
  input  logic             i_ls_req,
  input  logic             i_ls_we,
  input  logic [WIDTH-1:0] i_ls_addr,
  input  logic [31:0]      i_ls_wdata,
  output logic             o_ls_gnt,
  output logic             o_ls_rvalid,
  output logic [31:0]      o_ls_rdata,
  output logic             o_we,
  output logic [WIDTH-1:0] o_addr,
  output logic [31:0]      o_data,
  input  logic [31:0]      i_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_LS = 2'd2
  } resp_state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  resp_state_t      state_reg;
  resp_state_t      state_next;
  logic [WIDTH-1:0] addr_reg;
  logic [3:0]       wait_reg;
  logic [3:0]       wait_next;
  logic             fetch_wins;
  logic             if_gnt;
  logic             ls_gnt;
  logic [1:0]       resp_hit;
  logic [31:0]      resp_data [2];

`ifdef MEM_ARB_RR_EN
  // Remembers whether load/store took the most recent grant; reset favours load/store first.
  logic last_ls_reg;
  logic last_ls_next;

  assign fetch_wins = last_ls_reg;

  always_comb begin
    last_ls_next = last_ls_reg;
    if (if_gnt) begin
      last_ls_next = 1'b0;
    end else if (ls_gnt) begin
      last_ls_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls_reg <= 1'b0;
    end else begin
      last_ls_reg <= last_ls_next;
    end
  end

  assign wait_next = 4'd0;
`else
  assign fetch_wins = (wait_reg == MAX_WAIT_C);

  // Counts consecutive cycles a fetch has been left waiting.
  always_comb begin
    wait_next = 4'd0;
    if (i_if_req && !if_gnt) begin
      if (wait_reg >= MAX_WAIT_C) begin
        wait_next = MAX_WAIT_C;
      end else begin
        wait_next = wait_reg + 4'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_reg <= 4'd0;
    end else begin
      wait_reg <= wait_next;
    end
  end

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!rst) begin
      if (i_if_req && i_ls_req) begin
        if_gnt = fetch_wins;
        ls_gnt = !fetch_wins;
      end else begin
        if_gnt = i_if_req;
        ls_gnt = i_ls_req;
      end
    end
  end

  assign o_if_gnt = if_gnt;
  assign o_ls_gnt = ls_gnt;
  assign o_we     = ls_gnt && i_ls_we;
  assign o_data   = i_ls_wdata;

  // With no grant the RAM address keeps the last issued one.
  always_comb begin
    o_addr = addr_reg;
    if (rst) begin
      o_addr = '0;
    end else if (if_gnt) begin
      o_addr = i_if_addr;
    end else if (ls_gnt) begin
      o_addr = i_ls_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
    end else begin
      addr_reg <= o_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (if_gnt) begin
      state_next = RESP_IF;
    end else if (ls_gnt && !i_ls_we) begin
      state_next = RESP_LS;
    end
  end

  // Index 0 is the fetch port, index 1 the load/store port.
  always_comb begin
    resp_hit = 2'b00;
    if (!rst) begin
      resp_hit[0] = (state_reg == RESP_IF);
      resp_hit[1] = (state_reg == RESP_LS);
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign resp_data[gi] = resp_hit[gi] ? i_data : 32'd0;
  end

  assign o_if_rvalid = resp_hit[0];
  assign o_if_rdata  = resp_data[0];
  assign o_ls_rvalid = resp_hit[1];
  assign o_ls_rdata  = resp_data[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural one-cycle-latency RAM.
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int MW = 4;

  logic          clk;
  logic          rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic          o_if_rvalid;
  logic [31:0]   o_if_rdata;
  logic          i_ls_req;
  logic          i_ls_we;
  logic [AW-1:0] i_ls_addr;
  logic [31:0]   i_ls_wdata;
  logic          o_ls_gnt;
  logic          o_ls_rvalid;
  logic [31:0]   o_ls_rdata;
  logic          o_we;
  logic [AW-1:0] o_addr;
  logic [31:0]   o_data;
  logic [31:0]   i_data;

  mem_arbiter #(.WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt),
    .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
    .o_we(o_we), .o_addr(o_addr), .o_data(o_data), .i_data(i_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return {4'hA, a, 4'h5, ~a};
  endfunction

  // Behavioural RAM: unwritten words read back as pat(addr).
  logic [31:0] ram [int];
  always @(posedge clk) begin
    logic [31:0] rd;
    rd = ram.exists(int'(o_addr)) ? ram[int'(o_addr)] : pat(o_addr);
    if (o_we) ram[int'(o_addr)] = o_data;
    i_data <= rd;
  end

  typedef struct packed {
    logic        v_if;
    logic        v_ls;
    logic [31:0] d;
  } resp_t;

  resp_t         exp_q[$];
  logic [31:0]   shadow [int];
  int            vec_cnt = 0;
  int            err_cnt = 0;
  int            cyc     = 0;
  int            wait_m  = 0;
  logic          last_ls_m = 1'b0;
  logic [AW-1:0] hold_m  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] shadow_rd(input logic [AW-1:0] a);
    return shadow.exists(int'(a)) ? shadow[int'(a)] : pat(a);
  endfunction

  task automatic step(input logic ifr, input logic [AW-1:0] ifa, input logic lsr,
                      input logic we, input logic [AW-1:0] lsa, input logic [31:0] wd,
                      input logic r);
    logic          eg_if;
    logic          eg_ls;
    logic [AW-1:0] ea;
    resp_t         e;
    resp_t         n;
    @(negedge clk);
    rst = r; i_if_req = ifr; i_if_addr = ifa;
    i_ls_req = lsr; i_ls_we = we; i_ls_addr = lsa; i_ls_wdata = wd;
    #1;
    eg_if = 1'b0;
    eg_ls = 1'b0;
    if (!r) begin
      if (ifr && lsr) begin
`ifdef MEM_ARB_RR_EN
        eg_if = last_ls_m;
`else
        eg_if = (wait_m == MW);
`endif
        eg_ls = !eg_if;
      end else begin
        eg_if = ifr;
        eg_ls = lsr;
      end
    end
    ea = r ? '0 : eg_if ? ifa : eg_ls ? lsa : hold_m;

    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (r) e = '0;

    chk("if_gnt", 32'(o_if_gnt), 32'(eg_if));
    chk("ls_gnt", 32'(o_ls_gnt), 32'(eg_ls));
    chk("addr", 32'(o_addr), 32'(ea));
    chk("we", 32'(o_we), 32'(eg_ls && we));
    chk("if_rvalid", 32'(o_if_rvalid), 32'(e.v_if));
    chk("if_rdata", o_if_rdata, e.v_if ? e.d : 32'd0);
    chk("ls_rvalid", 32'(o_ls_rvalid), 32'(e.v_ls));
    chk("ls_rdata", o_ls_rdata, e.v_ls ? e.d : 32'd0);
    if (eg_ls && we) chk("wdata", o_data, wd);

    $display("cyc %0d rst=%0b if_gnt=%0b ls_gnt=%0b we=%0b addr=%h if_rv=%0b ls_rv=%0b",
             cyc, r, o_if_gnt, o_ls_gnt, o_we, o_addr, o_if_rvalid, o_ls_rvalid);

    n = '0;
    if (eg_if) begin
      n.v_if = 1'b1;
      n.d    = shadow_rd(ifa);
    end else if (eg_ls && !we) begin
      n.v_ls = 1'b1;
      n.d    = shadow_rd(lsa);
    end
    exp_q.push_back(n);
    if (eg_ls && we) shadow[int'(lsa)] = wd;

    hold_m = ea;
    if (r) begin
      wait_m    = 0;
      last_ls_m = 1'b0;
    end else begin
`ifdef MEM_ARB_RR_EN
      wait_m = 0;
`else
      if (ifr && !eg_if) wait_m = (wait_m >= MW) ? MW : wait_m + 1;
      else wait_m = 0;
`endif
      if (eg_if) last_ls_m = 1'b0;
      else if (eg_ls) last_ls_m = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0, '0, 32'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; i_if_req = 1'b0; i_if_addr = '0;
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_addr = '0; i_ls_wdata = '0;

    // Reset with both requesters active: nothing may be granted.
    repeat (3) step(1'b1, 12'h111, 1'b1, 1'b1, 12'h222, 32'h1234_5678, 1'b1);

    step(1'b1, 12'h010, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    step(1'b1, 12'h011, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    idle(2);

    step(1'b0, '0, 1'b1, 1'b1, 12'h020, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 12'h020, 32'd0, 1'b0);
    idle(2);

    // Continuous contention.
    for (int i = 0; i < 15; i++)
      step(1'b1, 12'(12'h100 + i), 1'b1, (i % 4) == 3, 12'(12'h200 + i), 32'(32'hC0DE_0000 + i), 1'b0);
    idle(1);

    // Fetch read outstanding when reset hits.
    step(1'b1, 12'h030, 1'b0, 1'b0, '0, 32'd0, 1'b0);
    step(1'b1, 12'h031, 1'b1, 1'b0, 12'h032, 32'd0, 1'b1);
    idle(2);

    // Contention from a fresh reset state.
    for (int i = 0; i < 6; i++)
      step(1'b1, 12'(12'h300 + i), 1'b1, 1'b0, 12'(12'h400 + i), 32'd0, 1'b0);
    idle(1);

    step(1'b0, '0, 1'b1, 1'b0, 12'h055, 32'd0, 1'b0);
    idle(3);

    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           12'($urandom_range(0, 15)), $urandom, 1'b0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
